// File: rtl/nested_agen_pkg.sv
// Shared types and helpers for the nested address generator.
// States, state width and config sanitising live here.
package nested_agen_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A zero bound or step would stall or never wrap; treat it as one.
    function automatic logic [31:0] sanitise(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/nested_agen_dim.sv
// One dimension of the nested counter: index register and wrap logic.
// carry_in means all inner dims wrap; carry_out extends that to this dim.
module nested_agen_dim
    import nested_agen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] idx,
    output logic             carry_out
);

    logic [WIDTH-1:0] idx_q;
    logic [WIDTH-1:0] idx_d;
    logic [WIDTH:0]   sum;
    logic             wrap_raw;

    // Wider sum so idx+step never overflows before the bound compare.
    always_comb begin
        sum       = {1'b0, idx_q} + {1'b0, step};
        wrap_raw  = (sum >= {1'b0, max});
        carry_out = carry_in & wrap_raw;
    end

    // Next index: clear, advance on carry, or hold.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (adv && carry_in) begin
            idx_d = wrap_raw ? '0 : sum[WIDTH-1:0];
        end
    end

    // Index register.
    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    assign idx = idx_q;

endmodule

// File: rtl/nested_addr_gen.sv
// Multi-dimensional address generator: nested counters plus stride MAC.
// Optional NESTED_AGEN_WRAP_FLAGS_EN adds a per-dimension wrap output.
module nested_addr_gen
    import nested_agen_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIMS   = 3,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_ld,
    input  logic [DIMS*WIDTH-1:0]    cfg_max,
    input  logic [DIMS*WIDTH-1:0]    cfg_step,
    input  logic [DIMS*ADDR_W-1:0]   cfg_stride,
    input  logic [ADDR_W-1:0]        cfg_base,
    input  logic                     start,
    input  logic                     clr,
    input  logic                     stall,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic [DIMS*WIDTH-1:0]    idx,
    output logic                     busy,
`ifdef NESTED_AGEN_WRAP_FLAGS_EN
    output logic [DIMS-1:0]          wrap,
`endif
    output logic                     done
);

    localparam int MW = ADDR_W + WIDTH;

    state_e state_q, state_d;

    logic [DIMS-1:0][WIDTH-1:0]  max_q, max_d;
    logic [DIMS-1:0][WIDTH-1:0]  step_q, step_d;
    logic [DIMS-1:0][ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0]           base_q, base_d;

    logic [DIMS-1:0][WIDTH-1:0]  dim_idx;
    logic [DIMS-1:0][ADDR_W-1:0] term;
    logic [DIMS:0]               carry;
    logic                        idx_clr;
    logic                        adv;
    logic                        accept;
    logic                        all_wrap;

    assign carry[0] = 1'b1;
    assign all_wrap = carry[DIMS];

    genvar g;
    generate
        for (g = 0; g < DIMS; g++) begin : g_dim
            nested_agen_dim #(.WIDTH(WIDTH)) u_dim (
                .clk       (clk),
                .rst       (rst),
                .clr       (idx_clr),
                .adv       (adv),
                .carry_in  (carry[g]),
                .max       (max_q[g]),
                .step      (step_q[g]),
                .idx       (dim_idx[g]),
                .carry_out (carry[g+1])
            );
            assign idx[g*WIDTH +: WIDTH] = dim_idx[g];
            assign term[g] = ADDR_W'(MW'(dim_idx[g]) * MW'(stride_q[g]));
`ifdef NESTED_AGEN_WRAP_FLAGS_EN
            assign wrap[g] = out_valid & carry[g+1];
`endif
        end
    endgenerate

    // Handshake and status outputs; clr and stall suppress beats and done.
    always_comb begin
        busy      = (state_q == ST_RUN);
        out_valid = busy && !stall && !clr;
        accept    = out_valid && out_ready;
        out_last  = out_valid && all_wrap;
        done      = (state_q == ST_DONE) && !stall && !clr;
    end

    // Linear address: base plus truncated index*stride terms.
    always_comb begin
        out_addr = base_q;
        for (int d = 0; d < DIMS; d++) begin
            out_addr = out_addr + term[d];
        end
    end

    // FSM next state, config capture and counter control.
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        step_d   = step_q;
        stride_d = stride_q;
        base_d   = base_q;
        idx_clr  = 1'b0;
        adv      = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            idx_clr = 1'b1;
        end else if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_ld) begin
                        for (int d = 0; d < DIMS; d++) begin
                            max_d[d] = WIDTH'(sanitise(
                                32'(cfg_max[d*WIDTH +: WIDTH])));
                            step_d[d] = WIDTH'(sanitise(
                                32'(cfg_step[d*WIDTH +: WIDTH])));
                            stride_d[d] = cfg_stride[d*ADDR_W +: ADDR_W];
                        end
                        base_d = cfg_base;
                    end else if (start) begin
                        idx_clr = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        adv = 1'b1;
                        if (all_wrap) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and config registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            max_q    <= '0;
            step_q   <= '0;
            stride_q <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            step_q   <= step_d;
            stride_q <= stride_d;
            base_q   <= base_d;
        end
    end

endmodule

// File: tb/tb_nested_addr_gen.sv
// Directed bench for nested_addr_gen with DIMS=2.
// Expected values are hand-computed address and index tables.
module tb_nested_addr_gen;

    localparam int WIDTH  = 8;
    localparam int DIMS   = 2;
    localparam int ADDR_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_ld;
    logic [DIMS*WIDTH-1:0]  cfg_max;
    logic [DIMS*WIDTH-1:0]  cfg_step;
    logic [DIMS*ADDR_W-1:0] cfg_stride;
    logic [ADDR_W-1:0]      cfg_base;
    logic                   start;
    logic                   clr;
    logic                   stall;
    logic                   out_ready;
    logic                   out_valid;
    logic [ADDR_W-1:0]      out_addr;
    logic                   out_last;
    logic [DIMS*WIDTH-1:0]  idx;
    logic                   busy;
    logic                   done;
`ifdef NESTED_AGEN_WRAP_FLAGS_EN
    logic [DIMS-1:0]        wrap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    nested_addr_gen #(
        .WIDTH  (WIDTH),
        .DIMS   (DIMS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_ld     (cfg_ld),
        .cfg_max    (cfg_max),
        .cfg_step   (cfg_step),
        .cfg_stride (cfg_stride),
        .cfg_base   (cfg_base),
        .start      (start),
        .clr        (clr),
        .stall      (stall),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .idx        (idx),
        .busy       (busy),
`ifdef NESTED_AGEN_WRAP_FLAGS_EN
        .wrap       (wrap),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_start();
        cfg_ld = 1'b1;
        tick();
        cfg_ld = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    logic [15:0] exp1 [6];
    logic [15:0] exp2_addr [6];
    logic [15:0] exp2_idx [6];

    initial begin
        exp1      = '{16'h10, 16'h11, 16'h12, 16'h14, 16'h15, 16'h16};
        exp2_addr = '{16'h00, 16'h02, 16'h04, 16'h10, 16'h12, 16'h14};
        exp2_idx  = '{16'h0000, 16'h0002, 16'h0004,
                      16'h0100, 16'h0102, 16'h0104};

        rst = 1'b1; cfg_ld = 1'b0; start = 1'b0; clr = 1'b0;
        stall = 1'b0; out_ready = 1'b1;
        cfg_max = '0; cfg_step = '0; cfg_stride = '0; cfg_base = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_busy",  busy,      0);
        check("rst_valid", out_valid, 0);
        check("rst_addr",  out_addr,  0);
        check("rst_last",  out_last,  0);
        check("rst_done",  done,      0);
        check("rst_idx",   idx,       0);

        // 3x2 walk, strides 1 and 4, base 0x10
        cfg_max    = {8'd2, 8'd3};
        cfg_step   = {8'd1, 8'd1};
        cfg_stride = {16'd4, 16'd1};
        cfg_base   = 16'h10;
        load_and_start();
        check("t1_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_valid%0d", i), out_valid, 1);
            check($sformatf("t1_addr%0d", i), out_addr, exp1[i]);
            check($sformatf("t1_last%0d", i), out_last, (i == 5) ? 1 : 0);
            tick();
        end
        check("t1_done",   done,      1);
        check("t1_dbusy",  busy,      0);
        check("t1_dvalid", out_valid, 0);
        tick();
        check("t1_done_off", done, 0);
        check("t1_idle",     busy, 0);

        // step 2 over max 5, backpressure and stall mid-run
        cfg_max    = {8'd2, 8'd5};
        cfg_step   = {8'd1, 8'd2};
        cfg_stride = {16'h10, 16'd1};
        cfg_base   = 16'h0;
        load_and_start();
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                out_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check("t2_hold_addr", out_addr, exp2_addr[2]);
                    check("t2_hold_idx",  idx,      exp2_idx[2]);
                end
                out_ready = 1'b1;
                #1;
            end
            if (i == 3) begin
                stall = 1'b1;
                #1;
                check("t2_stall_valid", out_valid, 0);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("t2_stall_idx", idx, exp2_idx[3]);
                    check("t2_stall_v",   out_valid, 0);
                end
                stall = 1'b0;
                #1;
            end
            check($sformatf("t2_addr%0d", i), out_addr, exp2_addr[i]);
            check($sformatf("t2_idx%0d", i),  idx,      exp2_idx[i]);
            check($sformatf("t2_last%0d", i), out_last, (i == 5) ? 1 : 0);
            tick();
        end
        check("t2_done", done, 1);
        tick();

        // clr mid-run: back to idle, no done
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t3_idx_mid", idx, 16'h0002);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("t3_busy",  busy,      0);
        check("t3_valid", out_valid, 0);
        check("t3_idx",   idx,       0);
        check("t3_done",  done,      0);
        check("t3_base",  out_addr,  0);
        tick();
        check("t3_done2", done, 0);

        // rst mid-run: all outputs zero
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t4_busy",  busy,      0);
        check("t4_valid", out_valid, 0);
        check("t4_addr",  out_addr,  0);
        check("t4_idx",   idx,       0);
        check("t4_done",  done,      0);

        // zero bounds/steps: single beat at base
        cfg_max    = '0;
        cfg_step   = '0;
        cfg_stride = {16'd1, 16'd1};
        cfg_base   = 16'h1234;
        cfg_ld = 1'b1;
        start  = 1'b1;
        tick();
        check("t5_ld_start_ignored", busy, 0);
        cfg_ld = 1'b0;
        tick();
        start = 1'b0;
        check("t5_busy",  busy,      1);
        check("t5_valid", out_valid, 1);
        check("t5_addr",  out_addr,  16'h1234);
        check("t5_last",  out_last,  1);
        tick();
        check("t5_done",  done,      1);
        check("t5_dv",    out_valid, 0);
        tick();
        check("t5_done2", done, 0);
        check("t5_idle",  busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
